slcorem0_tickgen: RTL
=====================

Name: slcorem0_tickgen

Overview:
Multi-channel, runtime-programmable clock-enable generator for SLCore-M0 subsystems. It generalises the fixed-ratio SysTick enable/calibration generator to NUM_CH independent channels. Each channel has its own divider, which software can reprogram glitch-free through a valid/ready config port. Channel 0 drives the core STCLKEN/STCALIB; the remaining channels supply tick enables to system timers and watchdogs.

Parameters:
NUM_CH, 4, number of tick channels (1..16)
DIV_W, 18, divider/counter width in bits
DEFAULT_DIV, 1000, reset divide ratio for every channel (must be < 2^DIV_W)
CALIB_TENMS, 24'd0, STCALIB[23:0] TENMS value
CALIB_SKEW, 1'b1, STCALIB[24] SKEW flag

Ports:
SYS_FCLK  in  1  free-running clock; all logic on rising edge
SYS_SYSRESET  in  1  synchronous active-high reset
CH_EN  in  NUM_CH  per-channel run enable
CFG_VALID  in  1  config write request
CFG_READY  out  1  config write can be accepted
CFG_CH  in  4  target channel index
CFG_DIV  in  DIV_W  new divide ratio (0 = channel stopped)
CFG_ERR  out  1  one-cycle pulse: accepted write had CFG_CH >= NUM_CH
CH_PEND  out  NUM_CH  per-channel pending (not yet applied) divider
TICK_EN  out  NUM_CH  per-channel one-cycle tick enable
STCALIB  out  26  {NOREF, SKEW, TENMS} for channel 0

Behaviour:
- Clocking and reset: one clock, SYS_FCLK. Reset is synchronous and active-high on SYS_SYSRESET. No other clocks or resets exist.
- Reset values: TICK_EN=0, CFG_ERR=0, CH_PEND=0, STCALIB={1'b1,CALIB_SKEW,CALIB_TENMS}. Internal counters cnt[i]=0; active ratio div_act[i]=DEFAULT_DIV.
- Channel i is running when CH_EN[i]=1 and div_act[i]!=0.
- Running channel counting:
  - cnt increments by 1 per cycle.
  - When cnt==div_act-1, cnt wraps to 0 and TICK_EN[i] is registered high for exactly the next cycle.
  - Tick period equals div_act cycles exactly.
  - The first tick occurs div_act cycles after the first running cycle.
  - div_act=1 gives TICK_EN held continuously high.
- Channel not running: cnt is forced to 0 on the next edge and TICK_EN[i]=0. Disabling mid-count discards the partial count. Re-enabling restarts the count from 0.
- Config handshake:
  - CFG_READY = (CFG_CH >= NUM_CH) | ~CH_PEND[CFG_CH], combinational.
  - A write is accepted in a cycle where CFG_VALID & CFG_READY.
  - An accepted write to a valid channel stores CFG_DIV into div_pend[i] and sets CH_PEND[i] on the next edge.
  - An accepted write to an invalid channel changes no state and pulses CFG_ERR for one cycle.
- Divider update:
  - While CH_PEND[i]=1 on a running channel, div_pend is applied at the wrap edge: div_act<=div_pend, CH_PEND clears, cnt<=0. That wrap still produces its tick at the old ratio. The new period starts immediately.
  - While CH_PEND[i]=1 on a non-running channel, the update is applied on the next edge.
  - A write accepted in the same cycle as a wrap becomes pending and is applied at the following wrap.
  - A write to a non-running channel is applied one edge after CH_PEND rises, so CH_PEND is high for exactly one cycle.
- STCALIB:
  - NOREF (bit 25) = registered ~(CH_EN[0] & div_act[0]!=0).
  - SKEW and TENMS are constant from parameters.
- Reset asserted mid-operation: all state returns to reset values on that edge. Pending writes are lost.

Decomposition:
- Shared include slcorem0_tickgen_defs.vh holds:
  - STCALIB field positions (NOREF=25, SKEW=24, TENMS=23:0).
  - Max NUM_CH = 16 and the CFG_CH width of 4.
- One sub-module, slcorem0_tickgen_ch, instantiated NUM_CH times in a generate loop. It holds cnt, div_act, div_pend and the pend flag, and produces the TICK_EN and running outputs.
- Top level holds only the config decode, CFG_ERR and STCALIB.

Test Plan:
- Reset, CH_EN=4'hF, defaults -> first TICK_EN on each channel exactly 1000 cycles after enable, then every 1000 cycles; STCALIB[25]=0 one cycle after enable.
- Write ch1 DIV=5 while running mid-count (cnt=300) -> CH_PEND[1]=1 and CFG_READY for ch1 low until the wrap at cnt=999; that tick still occurs at period 1000; subsequent ticks every 5 cycles.
- Second write to ch1 while CH_PEND[1]=1 -> CFG_READY=0, write not accepted; retry after the apply is accepted.
- CH_EN[2]=0 at cnt=500, then re-enable 10 cycles later -> no tick while disabled; next tick exactly 1000 cycles after re-enable.
- Write ch3 DIV=0, then DIV=1 -> ch3 stops (no ticks, cnt=0); after DIV=1, TICK_EN[3] held high from 1 cycle after apply.
- Write CFG_CH=9 with NUM_CH=4 -> CFG_READY=1, CFG_ERR high for 1 cycle, no CH_PEND change. Assert SYS_SYSRESET with ch0 pending -> CH_PEND=0, div_act back to 1000.

Source files
------------

// File: rtl/slcorem0_tickgen_pkg.sv
// Shared constants and helpers for the SLCore-M0 tick generator.
// STCALIB field layout and config channel index width live here.
package slcorem0_tickgen_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned CH_W   = 4;

  localparam int unsigned STC_W        = 26;
  localparam int unsigned STC_NOREF    = 25;
  localparam int unsigned STC_SKEW     = 24;
  localparam int unsigned STC_TENMS_HI = 23;
  localparam int unsigned STC_TENMS_LO = 0;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_WRAP = 2'd2
  } ch_mode_e;

  function automatic logic ch_in_range(
    input logic [CH_W-1:0] ch,
    input int unsigned     n
  );
    return 32'(ch) < n;
  endfunction

endpackage

// File: rtl/slcorem0_tickgen_ch.sv
// One tick channel: counter, active/pending divider and tick flop.
// Pending ratios are swapped in only at a wrap or while stopped.
module slcorem0_tickgen_ch
  import slcorem0_tickgen_pkg::*;
#(
  parameter int unsigned DIV_W       = 18,
  parameter int unsigned DEFAULT_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             running,
  output logic             pend
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  ch_mode_e         mode;

  assign running = en & (div_act_q != '0);
  assign tick    = tick_q;
  assign pend    = pend_q;

  always_comb begin
    mode = CH_IDLE;
    if (running) begin
      if (cnt_q == div_act_q - DIV_W'(1)) begin
        mode = CH_WRAP;
      end else begin
        mode = CH_RUN;
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    unique case (mode)
      CH_IDLE: cnt_d = '0;
      CH_RUN:  cnt_d = cnt_q + DIV_W'(1);
      CH_WRAP: begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end
      default: cnt_d = '0;
    endcase
    // The wrap tick keeps the old ratio; the new one starts right after
    if (pend_q && (mode != CH_RUN)) begin
      div_act_d = div_pend_q;
      pend_d    = 1'b0;
    end
    if (wr) begin
      div_pend_d = wr_div;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_W'(DEFAULT_DIV);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  end

endmodule

// File: rtl/slcorem0_tickgen.sv
// Multi-channel clock-enable generator with runtime divider config.
// Channel 0 also drives the core STCALIB NOREF flag.
module slcorem0_tickgen
  import slcorem0_tickgen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 18,
  parameter int unsigned DEFAULT_DIV = 1000,
  parameter logic [23:0] CALIB_TENMS = 24'd0,
  parameter logic        CALIB_SKEW  = 1'b1
) (
  input  logic              SYS_FCLK,
  input  logic              SYS_SYSRESET,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [DIV_W-1:0]  CFG_DIV,
  output logic              CFG_ERR,
  output logic [NUM_CH-1:0] CH_PEND,
  output logic [NUM_CH-1:0] TICK_EN,
  output logic [STC_W-1:0]  STCALIB
);

  localparam logic [NUM_CH-1:0] NOREF_MASK = NUM_CH'(1);

  logic [MAX_CH-1:0] pend_pad;
  logic [NUM_CH-1:0] run_vec;
  logic [NUM_CH-1:0] wr_vec;
  logic              ch_ok;
  logic              accept;
  logic              err_q, err_d;
  logic              noref_q, noref_d;

  always_comb begin
    pend_pad             = '0;
    pend_pad[NUM_CH-1:0] = CH_PEND;
  end

  assign ch_ok     = ch_in_range(CFG_CH, NUM_CH);
  assign CFG_READY = ~ch_ok | ~pend_pad[CFG_CH];
  assign accept    = CFG_VALID & CFG_READY;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_vec[i] = accept & ch_ok & (CFG_CH == CH_W'(i));

    slcorem0_tickgen_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (SYS_FCLK),
      .rst    (SYS_SYSRESET),
      .en     (CH_EN[i]),
      .wr     (wr_vec[i]),
      .wr_div (CFG_DIV),
      .tick   (TICK_EN[i]),
      .running(run_vec[i]),
      .pend   (CH_PEND[i])
    );
  end

  always_comb begin
    err_d   = accept & ~ch_ok;
    noref_d = ~|(run_vec & NOREF_MASK);
  end

  always_ff @(posedge SYS_FCLK) begin
    if (SYS_SYSRESET) begin
      err_q   <= 1'b0;
      noref_q <= 1'b1;
    end else begin
      err_q   <= err_d;
      noref_q <= noref_d;
    end
  end

  assign CFG_ERR = err_q;

  always_comb begin
    STCALIB                             = '0;
    STCALIB[STC_NOREF]                  = noref_q;
    STCALIB[STC_SKEW]                   = CALIB_SKEW;
    STCALIB[STC_TENMS_HI:STC_TENMS_LO]  = CALIB_TENMS;
  end

endmodule
